// File: rtl/op_reshuffle_buf.sv
// Lane-interleaved <-> element-ordered operand reshuffler with vl tracking and a 2-entry output buffer.
// Build with OP_RESHUFFLE_REVERSE_EN defined to add the shuffle (element -> lane layout) direction.
module op_reshuffle_buf #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VlWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [1:0]              cfg_vsew_i,
    input  logic [VlWidth-1:0]      cfg_vl_i,
    input  logic                    cfg_dir_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [NrLanes*64-1:0]   in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [NrLanes*64-1:0]   out_data_o,
    output logic [NrLanes*8-1:0]    out_strb_o,
    output logic                    out_last_o
);

    localparam int unsigned DataWidth = 64;
    localparam int unsigned NB        = NrLanes * 8;
    localparam int unsigned W         = NrLanes * DataWidth;
    localparam int unsigned IdxW      = $clog2(NB);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [1:0]           vsew_q, vsew_d;
    logic [VlWidth-1:0]   rem_q, rem_d;
    logic [VlWidth-1:0]   epb, valid_elems;
    logic                 beat_last;
    logic                 dir;

    logic [W-1:0]         fdata_q [2];
    logic [NB-1:0]        fstrb_q [2];
    logic [1:0]           flast_q;
    logic                 wptr_q, rptr_q;
    logic [1:0]           count_q, count_d;
    logic                 push, pop;

    logic [7:0]           in_b   [NB];
    logic [7:0]           perm_b [NB];
    logic [NB-1:0]        perm_strb;
    logic [W-1:0]         perm_data;

`ifdef OP_RESHUFFLE_REVERSE_EN
    logic dir_q, dir_d;
    assign dir = dir_q;
`else
    logic unused_dir;
    assign unused_dir = cfg_dir_i;
    assign dir        = 1'b0;
`endif

    function automatic int unsigned bitrev(input int unsigned x, input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < n) r = r | (((x >> i) & 1) << (n - 1 - i));
        end
        return r;
    endfunction

    // Lane-layout byte feeding element-ordered byte ob.
    function automatic int unsigned src_byte(input int unsigned ob, input logic [1:0] sew);
        int unsigned eb, e, lane, slot;
        eb   = 1 << sew;
        e    = ob >> sew;
        lane = e % NrLanes;
        slot = bitrev(e / NrLanes, 3 - 32'(sew));
        return lane * 8 + slot * eb + (ob % eb);
    endfunction

    assign cfg_ready_o = (state_q == IDLE);
    assign in_ready_o  = (state_q == RUN) && (count_q != 2'd2);
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = (count_q != 2'd0);
    assign pop         = out_valid_o && out_ready_i;
    assign count_d     = count_q + 2'(push) - 2'(pop);

    assign out_data_o  = out_valid_o ? fdata_q[rptr_q] : '0;
    assign out_strb_o  = out_valid_o ? fstrb_q[rptr_q] : '0;
    assign out_last_o  = out_valid_o && flast_q[rptr_q];

    always_comb begin
        case (vsew_q)
            2'd0:    epb = VlWidth'(NrLanes * 8);
            2'd1:    epb = VlWidth'(NrLanes * 4);
            2'd2:    epb = VlWidth'(NrLanes * 2);
            default: epb = VlWidth'(NrLanes);
        endcase
        valid_elems = (rem_q < epb) ? rem_q : epb;
        beat_last   = (rem_q <= epb);
    end

    always_comb begin
        int unsigned src;
        logic        elem_ok;
        src       = 0;
        elem_ok   = 1'b0;
        perm_strb = '0;
        perm_data = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            in_b[IdxW'(i)]   = in_data_i[8*i +: 8];
            perm_b[IdxW'(i)] = 8'h00;
        end
        for (int unsigned ob = 0; ob < NB; ob++) begin
            src     = src_byte(ob, vsew_q);
            elem_ok = ((ob >> vsew_q) < 32'(valid_elems));
            if (dir) begin
                // Shuffle: mask in element order, then scatter to lane layout.
                perm_b[IdxW'(src)]    = elem_ok ? in_b[IdxW'(ob)] : 8'h00;
                perm_strb[IdxW'(src)] = elem_ok;
            end else begin
                perm_b[IdxW'(ob)]    = elem_ok ? in_b[IdxW'(src)] : 8'h00;
                perm_strb[IdxW'(ob)] = elem_ok;
            end
        end
        for (int unsigned i = 0; i < NB; i++) begin
            perm_data[8*i +: 8] = perm_b[IdxW'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        vsew_d  = vsew_q;
        rem_d   = rem_q;
`ifdef OP_RESHUFFLE_REVERSE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    vsew_d = cfg_vsew_i;
                    rem_d  = cfg_vl_i;
`ifdef OP_RESHUFFLE_REVERSE_EN
                    dir_d  = cfg_dir_i;
`endif
                    if (cfg_vl_i != '0) state_d = RUN;
                end
            end
            RUN: begin
                if (push) begin
                    rem_d = rem_q - valid_elems;
                    if (beat_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final pop happens so cfg_ready_o rises the next cycle.
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vsew_q  <= '0;
            rem_q   <= '0;
`ifdef OP_RESHUFFLE_REVERSE_EN
            dir_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                fstrb_q[i] <= '0;
            end
            flast_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            vsew_q  <= vsew_d;
            rem_q   <= rem_d;
`ifdef OP_RESHUFFLE_REVERSE_EN
            dir_q   <= dir_d;
`endif
            if (push) begin
                fdata_q[wptr_q] <= perm_data;
                fstrb_q[wptr_q] <= perm_strb;
                flast_q[wptr_q] <= beat_last;
                wptr_q          <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            count_q <= count_d;
        end
    end

endmodule
